// File: rtl/alu_share_pkg.sv
// alu_share_pkg: definitions shared by the ALU time-sharing controller.
//   state_t   : FSM state encoding (IDLE / EXEC / RESP)
//   WIDTH_DEF : default operand/result width
//   SEL_W_DEF : default ALU select width
package alu_share_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SEL_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   req         in  N      request vector
//   last_grant  in  IDX_W  index granted most recently
//   grant       out N      one-hot grant (zero when no request)
//   grant_idx   out IDX_W  encoded winner index
//   grant_valid out 1      some request is being granted
// The search starts at last_grant+1 and wraps, so the most recent winner
// has the lowest priority.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IDX_W'((int'(last_grant) + off) % N);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: time-shares one combinational ALU between NUM_REQ clients.
//   clk, rst_n           clock (rising edge), async active-low reset
//   req_valid/req_ready  per-requester request handshake (ready one-hot or 0)
//   req_a/req_b/req_sel  packed operands and select, requester i in slice i
//   resp_valid/ready     per-requester response handshake (valid one-hot or 0)
//   resp_data/resp_zero  captured ALU result and zero flag (shared)
//   alu_*                connection to the external ALU instance
//   busy                 high while an operation is in EXEC or RESP
//   op_count             completed operations, wraps
//   dbg_state            current FSM state
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid is never withdrawn by this block once raised, while
// ready may be combinational from valid.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*SEL_W-1:0] req_sel,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]         resp_data,
    output logic                     resp_zero,
    output logic [WIDTH-1:0]         alu_input0,
    output logic [WIDTH-1:0]         alu_input1,
    output logic [SEL_W-1:0]         alu_select,
    input  logic [WIDTH-1:0]         alu_output0,
    input  logic                     alu_zero,
    output logic                     busy,
    output logic [CNT_W-1:0]         op_count,
    output logic [1:0]               dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
    logic [IDX_W-1:0]  id_q, id_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              zf_q, zf_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req         (req_valid),
        .last_grant  (last_grant_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= '0;
            res_q        <= '0;
            zf_q         <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sel_q        <= sel_d;
            res_q        <= res_d;
            zf_q         <= zf_d;
            op_count_q   <= op_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        sel_d        = sel_q;
        res_d        = res_q;
        zf_d         = zf_q;
        op_count_d   = op_count_q;
        case (state_q)
            IDLE: begin
                // In IDLE the arbiter's grant is req_ready, so a valid
                // grant is by construction a completed request handshake.
                if (arb_valid) begin
                    id_d    = arb_idx;
                    a_d     = req_a[arb_idx*WIDTH +: WIDTH];
                    b_d     = req_b[arb_idx*WIDTH +: WIDTH];
                    sel_d   = req_sel[arb_idx*SEL_W +: SEL_W];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_output0;
                zf_d    = alu_zero;
                state_d = RESP;
            end
            RESP: begin
                // Only the owning requester's ready bit completes the response.
                if (resp_ready[id_q]) begin
                    last_grant_d = id_q;
                    op_count_d   = op_count_q + CNT_W'(1);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready  = (state_q == IDLE) ? arb_grant : '0;
    assign resp_valid = (state_q == RESP) ? (NUM_REQ'(1) << id_q) : '0;
    assign resp_data  = res_q;
    assign resp_zero  = zf_q;
    assign alu_input0 = a_q;
    assign alu_input1 = b_q;
    assign alu_select = sel_q;
    assign busy       = (state_q != IDLE);
    assign op_count   = op_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

  localparam int NR = 2;
  localparam int W  = 32;
  localparam int SW = 4;
  localparam int CW = 8;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*W-1:0] req_a;
  logic [NR*W-1:0] req_b;
  logic [NR*SW-1:0] req_sel;
  logic [NR-1:0]   resp_valid;
  logic [NR-1:0]   resp_ready;
  logic [W-1:0]    resp_data;
  logic            resp_zero;
  logic [W-1:0]    alu_input0;
  logic [W-1:0]    alu_input1;
  logic [SW-1:0]   alu_select;
  logic [W-1:0]    alu_output0;
  logic            alu_zero;
  logic            busy;
  logic [CW-1:0]   op_count;
  logic [1:0]      dbg_state;

  int total = 0;
  int bad   = 0;

  alu_share_ctrl #(
    .NUM_REQ (NR),
    .WIDTH   (W),
    .SEL_W   (SW),
    .CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_sel     (req_sel),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_zero   (resp_zero),
    .alu_input0  (alu_input0),
    .alu_input1  (alu_input1),
    .alu_select  (alu_select),
    .alu_output0 (alu_output0),
    .alu_zero    (alu_zero),
    .busy        (busy),
    .op_count    (op_count),
    .dbg_state   (dbg_state)
  );

  // ALU model: add for 2, subtract for 6, AND for anything else
  always_comb begin
    case (alu_select)
      4'h2:    alu_output0 = alu_input0 + alu_input1;
      4'h6:    alu_output0 = alu_input0 - alu_input1;
      default: alu_output0 = alu_input0 & alu_input1;
    endcase
    alu_zero = (alu_output0 == '0);
  end

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          who;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [31:0] exp_data;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_req(input int who, input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
    req_a[who*W +: W]     = a;
    req_b[who*W +: W]     = b;
    req_sel[who*SW +: SW] = sel;
  endtask

  // one complete operation from IDLE with resp_ready held high
  task automatic do_op(input int who, input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
    set_req(who, a, b, sel);
    req_valid = onehot(who);
    #1;
    tick();
    req_valid = '0;
    tick();
    tick();
  endtask

  initial begin
    vecs[0] = '{0, 32'd5,          32'd3, 4'h2, 32'd8,          1'b0};
    vecs[1] = '{1, 32'd7,          32'd7, 4'h6, 32'd0,          1'b1};
    vecs[2] = '{0, 32'hFFFF_FFFF,  32'd1, 4'h2, 32'd0,          1'b1};
    vecs[3] = '{1, 32'd3,          32'd5, 4'h6, 32'hFFFF_FFFE,  1'b0};
    vecs[4] = '{0, 32'h0000_00F0,  32'h3C, 4'hF, 32'h0000_0030, 1'b0};

    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_sel    = '0;
    resp_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_alu_in0", alu_input0, 0);
    check("rst_state", dbg_state, 0);

    // contention straight out of reset: 0,1,0,1
    rst_n = 1'b1;
    set_req(0, 32'd10, 32'd1, 4'h2);
    set_req(1, 32'd20, 32'd2, 4'h6);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont_ready", req_ready, onehot(k % 2));
      tick();
      check("cont_exec", dbg_state, 1);
      tick();
      check("cont_resp_valid", resp_valid, onehot(k % 2));
      check("cont_resp_data", resp_data, (k % 2 == 0) ? 64'd11 : 64'd18);
      tick();
    end
    req_valid = '0;
    check("cont_op_count", op_count, 4);

    // table of single operations, response accepted as soon as it appears
    for (int i = 0; i < 5; i++) begin
      set_req(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].sel);
      req_valid = onehot(vecs[i].who);
      #1;
      check("vec_ready", req_ready, onehot(vecs[i].who));
      tick();
      req_valid = '0;
      check("vec_busy", busy, 1);
      check("vec_alu_in0", alu_input0, vecs[i].a);
      check("vec_alu_in1", alu_input1, vecs[i].b);
      check("vec_alu_sel", alu_select, vecs[i].sel);
      check("vec_exec_no_resp", resp_valid, 0);
      tick();
      check("vec_resp_valid", resp_valid, onehot(vecs[i].who));
      check("vec_resp_data", resp_data, vecs[i].exp_data);
      check("vec_resp_zero", resp_zero, vecs[i].exp_zero);
      tick();
      check("vec_resp_done", resp_valid, 0);
      check("vec_op_count", op_count, 64'(5 + i));
    end

    // backpressure with a second request waiting
    resp_ready = '0;
    set_req(0, 32'd1, 32'd2, 4'h2);
    req_valid = 2'b01;
    #1;
    check("bp_ready", req_ready, 2'b01);
    tick();
    set_req(1, 32'd100, 32'd50, 4'h6);
    req_valid = 2'b10;
    tick();
    resp_ready = 2'b10;
    for (int c = 0; c < 10; c++) begin
      check("bp_resp_valid", resp_valid, 2'b01);
      check("bp_resp_data", resp_data, 3);
      check("bp_req_ready", req_ready, 0);
      check("bp_busy", busy, 1);
      tick();
    end
    resp_ready = 2'b01;
    tick();
    check("bp_op_count", op_count, 10);
    check("bp_next_ready", req_ready, 2'b10);
    tick();
    check("bp_next_accept", alu_input0, 100);
    req_valid  = '0;
    resp_ready = '1;
    tick();
    check("bp2_resp_valid", resp_valid, 2'b10);
    check("bp2_resp_data", resp_data, 50);
    tick();
    check("bp2_op_count", op_count, 11);

    // request withdrawn before the edge
    set_req(0, 32'd9, 32'd9, 4'h2);
    req_valid = 2'b01;
    #1;
    check("drop_ready", req_ready, 2'b01);
    #2;
    req_valid = '0;
    tick();
    check("drop_idle", busy, 0);

    // reset while in EXEC, after requester 0 was the last winner
    do_op(0, 32'd4, 32'd4, 4'h2);
    check("pre_rst_count", op_count, 12);
    set_req(1, 32'd6, 32'd1, 4'h6);
    req_valid = 2'b10;
    #1;
    tick();
    req_valid = '0;
    check("mid_exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_op_count", op_count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_alu_in0", alu_input0, 0);
    tick();
    check("mid_rst_no_resp", resp_valid, 0);
    rst_n = 1'b1;
    set_req(0, 32'd2, 32'd2, 4'h2);
    req_valid = 2'b11;
    #1;
    check("post_rst_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    tick();
    check("post_rst_resp", resp_data, 4);
    tick();
    check("post_rst_count", op_count, 1);

    // counter wrap
    for (int n = 0; n < 254; n++) do_op(0, 32'd1, 32'd1, 4'h2);
    check("wrap_max", op_count, 255);
    do_op(1, 32'd1, 32'd1, 4'h2);
    check("wrap_zero", op_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
